// File: rtl/my_arb_pkg.sv
// Shared widths, types and the output-stage state encoding for the
// four-channel round-robin arbiter and its data mux.
package my_arb_pkg;

  localparam int DATA_W = 16;
  localparam int N_CH   = 4;
  localparam int SEL_W  = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  ch_idx_t;

  // Output register occupancy; FULL is exactly out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/my_mux_16_4_way.sv
// Plain 16-bit 4:1 data mux; sel picks a (0), b (1), c (2) or d (3).
module my_mux_16_4_way
  import my_arb_pkg::*;
(
  output word_t   out,
  input  word_t   a,
  input  word_t   b,
  input  word_t   c,
  input  word_t   d,
  input  ch_idx_t sel
);

  // Pure combinational select.
  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/my_rr_arbiter_16_4_way.sv
// Round-robin arbiter for four 16-bit producers feeding one consumer through
// a one-entry registered output stage.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both high there. Producers hold in_valid (and data)
// until accepted and must not derive in_valid from in_ready. The output stage
// holds out_data/out_src stable while out_valid is high and out_ready is low.
module my_rr_arbiter_16_4_way
  import my_arb_pkg::*;
#(
  parameter ch_idx_t RESET_PTR = 2'd3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  output logic [N_CH-1:0] in_ready,
  input  word_t           in_a,
  input  word_t           in_b,
  input  word_t           in_c,
  input  word_t           in_d,
  output logic            out_valid,
  input  logic            out_ready,
  output word_t           out_data,
  output ch_idx_t         out_src,
  output ch_idx_t         sel
);

  out_state_t state, state_nxt;
  ch_idx_t    ptr;       // last granted channel
  ch_idx_t    cand;
  logic       found;
  logic       load;      // output register can take a word this cycle
  logic       xfer;      // a producer word is accepted this cycle
  word_t      mux_out;

  // State is exported directly: FULL means the register holds a word.
  assign out_valid = (state == ST_FULL);
  assign load      = (state == ST_EMPTY) || out_ready;
  assign xfer      = rst_n && load && (|in_valid);

  // Rotating priority search starting just after the last winner; with no
  // request sel parks on ptr+1 so it is deterministic.
  always_comb begin
    sel   = ptr + 2'd1;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = ptr + ch_idx_t'(k);
      if (!found && in_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // One-hot accept for the winner, only when the word can actually move.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[sel] = 1'b1;
  end

  // Data path: the winner's word is selected by the shared mux block.
  my_mux_16_4_way u_mux (
    .out (mux_out),
    .a   (in_a),
    .b   (in_b),
    .c   (in_c),
    .d   (in_d),
    .sel (sel)
  );

  // Output stage next state: fill on a transfer, drain when the consumer
  // takes the word and nothing replaces it, otherwise hold.
  always_comb begin
    state_nxt = state;
    if (load) begin
      if (|in_valid) state_nxt = ST_FULL;
      else           state_nxt = ST_EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Output word, source tag and round-robin pointer update on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= RESET_PTR;
    end else if (xfer) begin
      out_data <= mux_out;
      out_src  <= sel;
      ptr      <= sel;
    end
  end

endmodule
